bgr_startup_ctrl: RTL and testbench

Digital start-up and trim sequencer for a bank of NUM_CH bandgap reference cores. It generates each core's start-up kick pulse (the `porst` gate drive of the start-up pull-down), waits for the core to settle, and qualifies the core's comparator "vbg good" flag. It reports ready or fault per channel and holds a per-channel resistor-ladder trim code, applying updates without a full restart. It sits between the always-on digital domain and the analog `bgr_top`-class cores.

---
 rtl/bgr_ctrl_pkg.sv | 16 +
 rtl/bgr_ch_seq.sv | 126 ++++++++++++
 rtl/bgr_startup_ctrl.sv | 50 +++++
 tb/tb_bgr_startup_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/bgr_ctrl_pkg.sv
// rtl/bgr_ctrl_pkg.sv - shared state encoding and reset constants for the bandgap start-up sequencer
package bgr_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KICK,
    ST_SETTLE,
    ST_CHECK,
    ST_READY,
    ST_FAULT
  } bgr_state_e;

  // Mid-scale ladder code so an untrimmed core starts near nominal.
  localparam int TRIM_RST = 16;

endpackage

// File: rtl/bgr_ch_seq.sv
// rtl/bgr_ch_seq.sv - one bandgap channel: vbg_ok synchroniser, start-up FSM, counters and trim register
module bgr_ch_seq
  import bgr_ctrl_pkg::*;
#(
  parameter int TRIM_W     = 5,
  parameter int PULSE_CYC  = 16,
  parameter int SETTLE_CYC = 256,
  parameter int MAX_RETRY  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              vbg_ok,
  input  logic [TRIM_W-1:0] trim_in,
  input  logic              trim_load,
  output logic              porst,
  output logic [TRIM_W-1:0] trim_out,
  output logic              ready,
  output logic              fault,
  output logic              busy
);

  localparam int CNT_MAX = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int RTY_W   = $clog2(MAX_RETRY) + 1;

  localparam logic [CNT_W-1:0]  PULSE_LD   = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0]  SETTLE_LD  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [RTY_W-1:0]  RTY_MAX    = RTY_W'(MAX_RETRY);
  localparam logic [TRIM_W-1:0] TRIM_RST_V = TRIM_W'(TRIM_RST);

  bgr_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RTY_W-1:0]  retry_q, retry_d;
  logic [TRIM_W-1:0] trim_q, trim_d;
  logic              sync1_q, ok_s_q;
  logic              porst_q, ready_q, fault_q, busy_q;
  logic              retry_left;

  assign retry_left = (retry_q < RTY_MAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    retry_d = retry_q;
    trim_d  = trim_load ? trim_in : trim_q;

    unique case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_KICK;
          cnt_d   = PULSE_LD;
        end
      end
      ST_KICK: begin
        if (cnt_q == '0) begin
          state_d = ST_SETTLE;
          cnt_d   = SETTLE_LD;
        end
      end
      ST_SETTLE: begin
        if (trim_load) begin
          cnt_d = SETTLE_LD;
        end else if (cnt_q == '0) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK, ST_READY: begin
        // A trim update in READY re-settles the core instead of re-kicking it.
        if (state_q == ST_READY && trim_load) begin
          state_d = ST_SETTLE;
          cnt_d   = SETTLE_LD;
        end else if (ok_s_q) begin
          state_d = ST_READY;
        end else if (retry_left) begin
          state_d = ST_KICK;
          cnt_d   = PULSE_LD;
          retry_d = retry_q + 1'b1;
        end else begin
          state_d = ST_FAULT;
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase

    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      retry_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      ok_s_q  <= 1'b0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      retry_q <= '0;
      trim_q  <= TRIM_RST_V;
      porst_q <= 1'b0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync1_q <= vbg_ok;
      ok_s_q  <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      trim_q  <= trim_d;
      porst_q <= (state_d == ST_KICK);
      ready_q <= (state_d == ST_READY);
      fault_q <= (state_d == ST_FAULT);
      busy_q  <= (state_d == ST_KICK) || (state_d == ST_SETTLE) || (state_d == ST_CHECK);
    end
  end

  assign porst    = porst_q;
  assign trim_out = trim_q;
  assign ready    = ready_q;
  assign fault    = fault_q;
  assign busy     = busy_q;

endmodule

// File: rtl/bgr_startup_ctrl.sv
// rtl/bgr_startup_ctrl.sv - start-up and trim sequencer for a bank of bandgap reference cores
module bgr_startup_ctrl
  import bgr_ctrl_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int TRIM_W     = 5,
  parameter int PULSE_CYC  = 16,
  parameter int SETTLE_CYC = 256,
  parameter int MAX_RETRY  = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        en,
  input  logic [NUM_CH-1:0]        vbg_ok,
  input  logic [NUM_CH*TRIM_W-1:0] trim_in,
  input  logic [NUM_CH-1:0]        trim_load,
  output logic [NUM_CH-1:0]        porst,
  output logic [NUM_CH*TRIM_W-1:0] trim_out,
  output logic [NUM_CH-1:0]        ready,
  output logic [NUM_CH-1:0]        fault,
  output logic                     busy
);

  logic [NUM_CH-1:0] busy_ch;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    bgr_ch_seq #(
      .TRIM_W    (TRIM_W),
      .PULSE_CYC (PULSE_CYC),
      .SETTLE_CYC(SETTLE_CYC),
      .MAX_RETRY (MAX_RETRY)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en[i]),
      .vbg_ok   (vbg_ok[i]),
      .trim_in  (trim_in[i*TRIM_W +: TRIM_W]),
      .trim_load(trim_load[i]),
      .porst    (porst[i]),
      .trim_out (trim_out[i*TRIM_W +: TRIM_W]),
      .ready    (ready[i]),
      .fault    (fault[i]),
      .busy     (busy_ch[i])
    );
  end

  // Per-channel busy flags are already registered, so the OR adds no latency.
  assign busy = |busy_ch;

endmodule

// File: tb/tb_bgr_startup_ctrl.sv
// tb/tb_bgr_startup_ctrl.sv - directed self-checking bench for bgr_startup_ctrl
module tb_bgr_startup_ctrl;

  localparam int NUM_CH = 4;
  localparam int TRIM_W = 5;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_CH-1:0]        en;
  logic [NUM_CH-1:0]        vbg_ok;
  logic [NUM_CH*TRIM_W-1:0] trim_in;
  logic [NUM_CH-1:0]        trim_load;
  logic [NUM_CH-1:0]        porst;
  logic [NUM_CH*TRIM_W-1:0] trim_out;
  logic [NUM_CH-1:0]        ready;
  logic [NUM_CH-1:0]        fault;
  logic                     busy;

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];
  int pulse_q[$];
  int run_len[NUM_CH];
  int k;

  bgr_startup_ctrl #(
    .NUM_CH    (NUM_CH),
    .TRIM_W    (TRIM_W),
    .PULSE_CYC (4),
    .SETTLE_CYC(8),
    .MAX_RETRY (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .vbg_ok   (vbg_ok),
    .trim_in  (trim_in),
    .trim_load(trim_load),
    .porst    (porst),
    .trim_out (trim_out),
    .ready    (ready),
    .fault    (fault),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Completed kick pulses are recorded as ch*100 + length in clocks.
  initial run_len = '{default: 0};
  always @(negedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (porst[c] === 1'b1) begin
        run_len[c] = run_len[c] + 1;
      end else if (run_len[c] != 0) begin
        pulse_q.push_back(c * 100 + run_len[c]);
        run_len[c] = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100us");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int which, input int ch);
    return (which == 0) ? ready[ch] : fault[ch];
  endfunction

  task automatic wait_level(input int which, input int ch, input logic val,
                            input int limit, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (sig(which, ch) !== val && cnt < limit);
  endtask

  task automatic pop_pulse(input string tag);
    int w = 0;
    while (pulse_q.size() == 0 && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (pulse_q.size() == 0 || exp_q.size() == 0)
      chk({tag, "_present"}, pulse_q.size(), 1);
    else
      chk(tag, pulse_q.pop_front(), exp_q.pop_front());
  endtask

  function automatic logic [19:0] tvec(input int t3, input int t2, input int t1, input int t0);
    return {5'(t3), 5'(t2), 5'(t1), 5'(t0)};
  endfunction

  initial begin
    rst_n     = 1'b0;
    en        = '0;
    vbg_ok    = 4'b1101;
    trim_in   = '0;
    trim_load = '0;
    repeat (3) @(negedge clk);
    chk("rst_porst", porst, 0);
    chk("rst_ready", ready, 0);
    chk("rst_fault", fault, 0);
    chk("rst_busy", busy, 0);
    chk("rst_trim", trim_out, tvec(16, 16, 16, 16));
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal start on channel 0
    en[0] = 1'b1;
    exp_q.push_back(4);
    @(negedge clk);
    chk("ch0_busy_kick", busy, 1);
    wait_level(0, 0, 1'b1, 40, k);
    chk("ch0_ready_lat", k + 1, 14);
    chk("ch0_busy_done", busy, 0);
    pop_pulse("ch0_kick");

    // Channel 1 never sees vbg_ok: three kicks then fault
    en[1] = 1'b1;
    repeat (3) exp_q.push_back(104);
    wait_level(1, 1, 1'b1, 80, k);
    chk("ch1_fault_lat", k, 40);
    chk("ch1_porst_fault", porst[1], 0);
    chk("ch1_busy_fault", busy, 0);
    pop_pulse("ch1_kick1");
    pop_pulse("ch1_kick2");
    pop_pulse("ch1_kick3");
    @(negedge clk);
    en[1] = 1'b0;
    @(negedge clk);
    chk("ch1_fault_clear", fault[1], 0);

    // Channel 2 dropout and recovery
    en[2] = 1'b1;
    exp_q.push_back(204);
    wait_level(0, 2, 1'b1, 40, k);
    chk("ch2_ready_lat", k, 14);
    pop_pulse("ch2_kick");
    @(negedge clk);
    vbg_ok[2] = 1'b0;
    exp_q.push_back(204);
    wait_level(0, 2, 1'b0, 10, k);
    chk("ch2_drop_lat", k, 3);
    repeat (2) @(negedge clk);
    vbg_ok[2] = 1'b1;
    wait_level(0, 2, 1'b1, 40, k);
    chk("ch2_recover_lat", k + 5, 16);
    pop_pulse("ch2_rekick");
    chk("ch2_single_rekick", pulse_q.size(), 0);

    // Channel 3 trim while READY
    en[3] = 1'b1;
    exp_q.push_back(304);
    wait_level(0, 3, 1'b1, 40, k);
    chk("ch3_ready_lat", k, 14);
    pop_pulse("ch3_kick");
    @(negedge clk);
    trim_in[19:15] = 5'd9;
    trim_load[3]   = 1'b1;
    @(negedge clk);
    trim_load[3] = 1'b0;
    chk("ch3_trim_code", trim_out, tvec(9, 16, 16, 16));
    chk("ch3_trim_ready_low", ready[3], 0);
    wait_level(0, 3, 1'b1, 40, k);
    chk("ch3_trim_low_cycles", k, 9);
    chk("ch3_trim_no_kick", pulse_q.size(), 0);

    // Simultaneous en fall and trim load
    @(negedge clk);
    en[3]          = 1'b0;
    trim_in[19:15] = 5'd3;
    trim_load[3]   = 1'b1;
    @(negedge clk);
    trim_load[3] = 1'b0;
    chk("ch3_off_ready", ready[3], 0);
    chk("ch3_off_trim", trim_out[19:15], 3);
    chk("ch3_off_busy", busy, 0);

    // Trim during SETTLE restarts the settle count
    en[3] = 1'b1;
    exp_q.push_back(304);
    repeat (8) @(negedge clk);
    trim_in[19:15] = 5'd12;
    trim_load[3]   = 1'b1;
    @(negedge clk);
    trim_load[3] = 1'b0;
    chk("ch3_settle_trim", trim_out[19:15], 12);
    wait_level(0, 3, 1'b1, 40, k);
    chk("ch3_settle_restart", k + 9, 18);
    pop_pulse("ch3_rekick");

    // Asynchronous reset in the middle of a kick
    @(negedge clk);
    vbg_ok[1] = 1'b1;
    en[1]     = 1'b1;
    exp_q.push_back(102);
    repeat (2) @(negedge clk);
    chk("ch1_kick_active", porst[1], 1);
    chk("ch1_busy_active", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_porst", porst, 0);
    chk("arst_ready", ready, 0);
    chk("arst_busy", busy, 0);
    chk("arst_trim", trim_out, tvec(16, 16, 16, 16));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(4);
    exp_q.push_back(104);
    exp_q.push_back(204);
    exp_q.push_back(304);
    wait_level(0, 1, 1'b1, 40, k);
    chk("ch1_post_rst_ready", k, 14);
    pop_pulse("ch1_cut_kick");
    pop_pulse("ch0_post_rst_kick");
    pop_pulse("ch1_post_rst_kick");
    pop_pulse("ch2_post_rst_kick");
    pop_pulse("ch3_post_rst_kick");
    chk("all_ready_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
